// File: rtl/ex_mdu_iter.sv
// Shared iterative multiply/divide unit for the EX stage.
// MUL is shift-add retiring MUL_BITS per cycle; DIV is restoring, one bit per cycle.
module ex_mdu_iter #(
  parameter int WIDTH    = 32,
  parameter int MUL_BITS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [1:0]           op_i,
  input  logic [WIDTH-1:0]     opa_i,
  input  logic [WIDTH-1:0]     opb_i,
  input  logic                 annul_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int PW = WIDTH + MUL_BITS;
  localparam logic [CW-1:0] MUL_LAST = CW'(WIDTH / MUL_BITS - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_CALC,
    S_FIX,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_op;
  logic [WIDTH-1:0]     r_a;
  logic [WIDTH-1:0]     r_b;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [CW-1:0]        r_cnt;
  logic                 r_neg_q;
  logic                 r_neg_r;
  logic [2*WIDTH-1:0]   r_result;
  logic                 r_div_zero;

  logic                 w_is_div;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_abs;
  logic [WIDTH-1:0]     w_b_abs;
  logic                 w_div_zero;
  logic [PW-1:0]        w_pp;
  logic [PW-1:0]        w_msum;
  logic [2*WIDTH+MUL_BITS-1:0] w_mcat;
  logic [WIDTH:0]       w_trial;
  logic                 w_ge;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_fix;

  // In PREP r_a/r_b still hold the raw captured operands.
  assign w_is_div   = r_op[1];
  assign w_a_neg    = r_op[0] & r_a[WIDTH-1];
  assign w_b_neg    = r_op[0] & r_b[WIDTH-1];
  assign w_a_abs    = w_a_neg ? -r_a : r_a;
  assign w_b_abs    = w_b_neg ? -r_b : r_b;
  assign w_div_zero = w_is_div && (r_b == '0);

  assign w_pp   = PW'(r_a) * PW'(r_lo[MUL_BITS-1:0]);
  assign w_msum = PW'(r_hi) + w_pp;
  assign w_mcat = {w_msum, r_lo};

  assign w_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
  assign w_ge    = ~w_trial[WIDTH];

  assign w_prod = {r_hi, r_lo};
  assign w_fix  = w_is_div ? {(r_neg_r ? -r_hi : r_hi), (r_neg_q ? -r_lo : r_lo)}
                           : (r_neg_q ? -w_prod : w_prod);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start_i && !annul_i) w_next = S_PREP;
      S_PREP: begin
        if (annul_i)         w_next = S_IDLE;
        else if (w_div_zero) w_next = S_DONE;
        else                 w_next = S_CALC;
      end
      S_CALC: begin
        if (annul_i)            w_next = S_IDLE;
        else if (r_cnt == '0)   w_next = S_FIX;
      end
      S_FIX:  w_next = annul_i ? S_IDLE : S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_op       <= '0;
      r_a        <= '0;
      r_b        <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            r_op <= op_i;
            r_a  <= opa_i;
            r_b  <= opb_i;
          end
        end
        S_PREP: begin
          r_a     <= w_a_abs;
          r_b     <= w_b_abs;
          r_hi    <= '0;
          r_lo    <= w_is_div ? w_a_abs : w_b_abs;
          r_cnt   <= w_is_div ? DIV_LAST : MUL_LAST;
          r_neg_q <= w_a_neg ^ w_b_neg;
          r_neg_r <= w_a_neg;
          if (w_div_zero && !annul_i) begin
            r_result   <= {r_a, {WIDTH{1'b1}}};
            r_div_zero <= 1'b1;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt - CW'(1);
          if (w_is_div) begin
            r_hi <= w_ge ? w_trial[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
            r_lo <= {r_lo[WIDTH-2:0], w_ge};
          end else begin
            r_hi <= w_mcat[2*WIDTH+MUL_BITS-1:WIDTH+MUL_BITS];
            r_lo <= w_mcat[WIDTH+MUL_BITS-1:MUL_BITS];
          end
        end
        S_FIX: begin
          if (!annul_i) begin
            r_result   <= w_fix;
            r_div_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = (r_state == S_DONE);
  assign result_o   = r_result;
  assign div_zero_o = r_div_zero;

endmodule

// File: tb/tb_ex_mdu_iter.sv
// Directed bench for ex_mdu_iter: vector table of MUL/DIV ops plus annul sequences.
module tb_ex_mdu_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [1:0]  op_i;
  logic [31:0] opa_i;
  logic [31:0] opb_i;
  logic        annul_i;
  logic        busy_o;
  logic        done_o;
  logic [63:0] result_o;
  logic        div_zero_o;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] MULTU = 2'b00, MULT = 2'b01, DIVU = 2'b10, DIV = 2'b11;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t vecs[15];

  ex_mdu_iter #(.WIDTH(32), .MUL_BITS(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start_i),
    .op_i       (op_i),
    .opa_i      (opa_i),
    .opb_i      (opb_i),
    .annul_i    (annul_i),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .result_o   (result_o),
    .div_zero_o (div_zero_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start at a negedge, scramble operands after capture, count edges to done_o.
  task automatic run_op(input int idx, input vec_t v);
    int cyc;
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    start_i = 1'b1;
    op_i    = v.op;
    opa_i   = v.a;
    opb_i   = v.b;
    @(posedge clk); #1;
    cyc     = 1;
    start_i = 1'b0;
    op_i    = ~v.op;
    opa_i   = ~v.a;
    opb_i   = v.b + 32'd3;
    while (!done_o && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, "_latency"}, 64'(cyc), 64'(v.lat));
    chk({tag, "_result"}, result_o, v.res);
    chk({tag, "_div_zero"}, 64'(div_zero_o), 64'(v.dz));
    @(posedge clk); #1;
    chk({tag, "_done_width"}, 64'(done_o), 64'd0);
    chk({tag, "_idle_after"}, 64'(busy_o), 64'd0);
  endtask

  logic [63:0] last_res;
  logic        last_dz;
  logic        saw_done;

  initial begin
    vecs[0]  = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 1'b0, 19};
    vecs[1]  = '{MULT,  32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 19};
    vecs[2]  = '{MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0, 19};
    vecs[3]  = '{MULTU, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, 1'b0, 19};
    vecs[4]  = '{MULT,  32'd5,         32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 19};
    vecs[5]  = '{MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 1'b0, 19};
    vecs[6]  = '{DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, 1'b0, 35};
    vecs[7]  = '{DIVU,  32'd7,         32'd2,         64'h0000_0001_0000_0003, 1'b0, 35};
    vecs[8]  = '{DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 1'b0, 35};
    vecs[9]  = '{DIVU,  32'd5,         32'd0,         64'h0000_0005_FFFF_FFFF, 1'b1, 2};
    vecs[10] = '{DIV,   32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 1'b0, 35};
    vecs[11] = '{DIVU,  32'hFFFF_FFFF, 32'd1,         64'h0000_0000_FFFF_FFFF, 1'b0, 35};
    vecs[12] = '{DIVU,  32'd3,         32'd5,         64'h0000_0003_0000_0000, 1'b0, 35};
    vecs[13] = '{DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 64'hFFFF_FFFF_0000_0003, 1'b0, 35};
    vecs[14] = '{DIV,   32'hFFFF_FFF7, 32'd0,         64'hFFFF_FFF7_FFFF_FFFF, 1'b1, 2};

    rst = 1'b1; start_i = 1'b0; annul_i = 1'b0; op_i = '0; opa_i = '0; opb_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_done", 64'(done_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    chk("reset_div_zero", 64'(div_zero_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) run_op(i, vecs[i]);
    last_res = vecs[14].res;
    last_dz  = vecs[14].dz;

    // start together with annul in IDLE must not launch anything
    @(negedge clk);
    start_i = 1'b1; annul_i = 1'b1; op_i = MULTU; opa_i = 32'd2; opb_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b0;
    chk("start_with_annul_busy", 64'(busy_o), 64'd0);

    // DIV annulled at T0+5 with a stray start at T0+3
    saw_done = 1'b0;
    @(negedge clk);
    start_i = 1'b1; op_i = DIV; opa_i = 32'd100; opb_i = 32'd7;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      if (done_o) saw_done = 1'b1;
      if (c == 3) begin
        start_i = 1'b1; op_i = MULTU; opa_i = 32'd9; opb_i = 32'd9;
      end else begin
        start_i = 1'b0;
      end
      if (c == 5) annul_i = 1'b1;
      @(posedge clk); #1;
    end
    annul_i = 1'b0; start_i = 1'b0;
    chk("annul_busy_T0p6", 64'(busy_o), 64'd0);
    for (int c = 0; c < 40; c++) begin
      if (done_o) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("annul_no_done", 64'(saw_done), 64'd0);
    chk("annul_result_held", result_o, last_res);
    chk("annul_div_zero_held", 64'(div_zero_o), 64'(last_dz));

    // annul during PREP of a divide by zero must not touch result/div_zero
    @(negedge clk);
    start_i = 1'b1; op_i = DIVU; opa_i = 32'd11; opb_i = 32'd0;
    @(posedge clk); #1;
    start_i = 1'b0; annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    chk("annul_prep_busy", 64'(busy_o), 64'd0);
    chk("annul_prep_done", 64'(done_o), 64'd0);
    chk("annul_prep_result", result_o, last_res);

    // normal operation resumes
    run_op(15, '{MULTU, 32'd6, 32'd7, 64'd42, 1'b0, 19});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "timeout");
  end

endmodule
